decoder_scan_driver: RTL and testbench



---
 rtl/decoder_scan_pkg.sv | 14 +
 rtl/decoder_scan_timer.sv | 34 +++
 rtl/decoder_scan_driver.sv | 143 ++++++++++++++
 tb/tb_decoder_scan_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and sizing helpers for the decoder scan driver.
package decoder_scan_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

  // Phase timer must hold 0 .. max(dwell, blank) - 1 without overflow.
  function automatic int unsigned timer_width(input int unsigned dwell,
                                               input int unsigned blank);
    int unsigned longest;
    longest = (dwell > blank) ? dwell : blank;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Phase timer: cleared by load, counts up and saturates at term_val,
// with term flagging that the terminal value has been reached.
module decoder_scan_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] term_val,
  output logic             term
);

  logic [WIDTH-1:0] count_q, count_d;

  assign term = (count_q == term_val);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (!term) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_scan_driver.sv
// Scan driver producing sel/ena for a SEL_W-to-2^SEL_W decoder.
// Define DECODER_SCAN_BIDIR_EN for ping-pong scanning instead of wrap-around.
module decoder_scan_driver #(
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [SEL_W-1:0] sel,
  output logic             ena,
  output logic             frame_done,
  output logic             busy
);

  import decoder_scan_pkg::*;

  localparam int unsigned TW = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [TW-1:0] DWELL_TERM = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_TERM = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam scan_state_t START_STATE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ena_q, ena_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] next_code;
  logic             code_turn;
  logic             timer_load;
  logic             timer_term;
  logic [TW-1:0]    term_val;

  assign term_val = (state_q == BLANK) ? BLANK_TERM : DWELL_TERM;

  decoder_scan_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .term_val (term_val),
    .term     (timer_term)
  );

`ifdef DECODER_SCAN_BIDIR_EN
  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  logic dir_down_q, dir_down_d;

  // Direction flips on the same edge that lands on an end code, so the
  // end code is driven once and the frame pulse marks the turnaround.
  always_comb begin
    next_code = dir_down_q ? sel_q - 1'b1 : sel_q + 1'b1;
    code_turn = dir_down_q ? (next_code == '0) : (next_code == SEL_MAX);
    dir_down_d = dir_down_q;
    if (!run || state_q == IDLE) begin
      dir_down_d = 1'b0;
    end else if (state_q == DRIVE && timer_term && code_turn) begin
      dir_down_d = ~dir_down_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_down_q <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
    end
  end
`else
  always_comb begin
    next_code = sel_q + 1'b1;
    code_turn = (next_code == '0);
  end
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    timer_load   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_load = 1'b1;
        sel_d      = '0;
        if (run) begin
          state_d = START_STATE;
        end
      end
      BLANK: begin
        if (!run) begin
          state_d    = IDLE;
          sel_d      = '0;
          timer_load = 1'b1;
        end else if (timer_term) begin
          state_d    = DRIVE;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (!run) begin
          state_d    = IDLE;
          sel_d      = '0;
          timer_load = 1'b1;
        end else if (timer_term) begin
          state_d      = START_STATE;
          sel_d        = next_code;
          frame_done_d = code_turn;
          timer_load   = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        sel_d      = '0;
        timer_load = 1'b1;
      end
    endcase
    ena_d  = (state_d == DRIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ena_q        <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ena_q        <= ena_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign ena        = ena_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed self-checking bench for decoder_scan_driver in three configurations.
module tb_decoder_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, run0 = 1'b0;
  logic rst1 = 1'b1, run1 = 1'b0;
  logic rst2 = 1'b1, run2 = 1'b0;

  logic [0:0] sel0;
  logic       ena0, fd0, busy0;
  logic [1:0] sel1;
  logic       ena1, fd1, busy1;
  logic [1:0] sel2;
  logic       ena2, fd2, busy2;

  int checks = 0;
  int errors = 0;

  // Downstream 1-to-2 decoder fed by u0.
  logic [1:0] dec_out;
  assign dec_out = ena0 ? (sel0[0] ? 2'b10 : 2'b01) : 2'b00;

  decoder_scan_driver #(.SEL_W(1), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) u0 (
    .clk(clk), .rst(rst0), .run(run0),
    .sel(sel0), .ena(ena0), .frame_done(fd0), .busy(busy0)
  );

  decoder_scan_driver #(.SEL_W(2), .DWELL_CYCLES(2), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst(rst1), .run(run1),
    .sel(sel1), .ena(ena1), .frame_done(fd1), .busy(busy1)
  );

  decoder_scan_driver #(.SEL_W(2), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) u2 (
    .clk(clk), .rst(rst2), .run(run2),
    .sel(sel2), .ena(ena2), .frame_done(fd2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vectors are {sel, ena, frame_done, busy}.
  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0;
    tick();
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_u0: got %b expected 0000", {sel0, ena0, fd0, busy0});
    end
    checks++;
    if ({sel1, ena1, fd1, busy1} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_u1: got %b expected 00000", {sel1, ena1, fd1, busy1});
    end
    checks++;
    if ({sel2, ena2, fd2, busy2} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_u2: got %b expected 00000", {sel2, ena2, fd2, busy2});
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_scan_frame();
    logic exp_ena [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp;
    run0 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp = {((c - 1) % 8) >= 4, exp_ena[(c - 1) % 8], (c == 9 || c == 17), 1'b1};
      checks++;
      if ({sel0, ena0, fd0, busy0} !== exp) begin
        errors++;
        $display("FAIL frame cycle %0d: got %b expected %b", c, {sel0, ena0, fd0, busy0}, exp);
      end
    end
  endtask

  task automatic test_stop_restart();
    int n = 0;
    while (!(sel0 == 1'b1 && ena0 == 1'b1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL stop_wait: code 1 DRIVE not seen within %0d cycles", n);
    end
    tick();
    run0 = 1'b0;
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_idle: got %b expected 0000", {sel0, ena0, fd0, busy0});
    end
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_hold: got %b expected 0000", {sel0, ena0, fd0, busy0});
    end
    run0 = 1'b1;
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0001) begin
      errors++;
      $display("FAIL restart_blank: got %b expected 0001", {sel0, ena0, fd0, busy0});
    end
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0101) begin
      errors++;
      $display("FAIL restart_drive: got %b expected 0101", {sel0, ena0, fd0, busy0});
    end
  endtask

  task automatic test_reset_mid_drive();
    int n = 0;
    while (!(sel0 == 1'b1 && ena0 == 1'b1) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL rst_wait: code 1 DRIVE not seen within %0d cycles", n);
    end
    rst0 = 1'b1;
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_drive: got %b expected 0000", {sel0, ena0, fd0, busy0});
    end
    rst0 = 1'b0;
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_restart_blank: got %b expected 0001", {sel0, ena0, fd0, busy0});
    end
    tick();
    checks++;
    if ({sel0, ena0, fd0, busy0} !== 4'b0101) begin
      errors++;
      $display("FAIL rst_restart_drive: got %b expected 0101", {sel0, ena0, fd0, busy0});
    end
  endtask

  task automatic test_decoder_view();
    logic [1:0] exp_out [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++;
      if (dec_out !== exp_out[(c - 1) % 8] || dec_out === 2'b11) begin
        errors++;
        $display("FAIL decoder_out cycle %0d: got %b expected %b", c, dec_out, exp_out[(c - 1) % 8]);
      end
    end
  endtask

  task automatic test_no_blank();
    logic [4:0] exp;
    run1 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp = {2'(((c - 1) / 2) % 4), 1'b1, (c == 9 || c == 17), 1'b1};
      checks++;
      if ({sel1, ena1, fd1, busy1} !== exp) begin
        errors++;
        $display("FAIL no_blank cycle %0d: got %b expected %b", c, {sel1, ena1, fd1, busy1}, exp);
      end
    end
  endtask

  task automatic test_scan_order();
`ifdef DECODER_SCAN_BIDIR_EN
    logic [1:0] exp_sel [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       exp_fd  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic [1:0] exp_sel [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_fd  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    logic [4:0] exp;
    run2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = {exp_sel[c], 1'b1, exp_fd[c], 1'b1};
      checks++;
      if ({sel2, ena2, fd2, busy2} !== exp) begin
        errors++;
        $display("FAIL scan_order cycle %0d: got %b expected %b", c + 1, {sel2, ena2, fd2, busy2}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_stop_restart();
    test_reset_mid_drive();
    test_decoder_view();
    test_no_blank();
    test_scan_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
